// File: rtl/bocong_noitiep_pkg.sv
// ---------------------------------------------------------------------------
// bocong_pkg
//   Shared definitions for the nibble-serial adder (bocong_noitiep).
//   - NIB_W            : width of one adder slice (one nibble)
//   - ST_IDLE/RUN/DONE : state encoding constants for the sequencer FSM
//   - state_t          : enum built on those constants
//   - idx_width()      : width of the nibble index counter, never below 1
// ---------------------------------------------------------------------------
package bocong_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // clog2 of the nibble count, clamped to 1 so a single-nibble build
  // still has a legal (if unused) counter bit.
  function automatic int idx_width(input int nibbles);
    int w;
    if (nibbles > 1) begin
      w = $clog2(nibbles);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bocong_noitiep_if.sv
// ---------------------------------------------------------------------------
// bocong_noitiep_if
//   Operand/result bundle of the nibble-serial adder.
//   master : the requester (drives start, a, b, cin; observes busy/done/s/cout)
//   slave  : the adder itself
//   Signals:
//     start     request strobe, honoured only while the adder is idle
//     a, b      W-bit operands (W = 4*NIBBLES)
//     cin       carry-in
//     busy      adder is running or presenting its result
//     done      one-cycle pulse, s/cout hold the finished result
//     s, cout   registered sum and final carry-out
// ---------------------------------------------------------------------------
interface bocong_noitiep_if
  import bocong_pkg::*;
#(
  parameter int NIBBLES = 4
) ();

  localparam int W = NIB_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout
  );

endinterface

// File: rtl/bocong_noitiep_cong4bit.sv
// ---------------------------------------------------------------------------
// cong4bit
//   Purely combinational 4-bit ripple-carry adder: {cout, s} = a + b + cin.
//   Ports:
//     a, b  [3:0]  addends
//     cin          carry into bit 0
//     cout         carry out of bit 3
//     s     [3:0]  sum
//   Built as an explicit chain of full adders so the carry path is the
//   familiar four-stage ripple.
// ---------------------------------------------------------------------------
module cong4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] s
);

  // c[i] is the carry into bit i; c[4] leaves the slice.
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign s[i]     = p ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (p & c[i]);
  end

  assign cout = c[4];

endmodule

// File: rtl/bocong_noitiep.sv
// ---------------------------------------------------------------------------
// bocong_noitiep
//   Nibble-serial W-bit adder (W = 4*NIBBLES). A start seen while idle
//   latches both operands and the carry-in; one nibble is then added per
//   clock, LSB first, through a single 4-bit ripple slice, with the carry
//   chained between cycles in a register. After the last nibble the final
//   carry is captured and done pulses for one cycle.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   bocong_noitiep_if.slave (start/a/b/cin in, busy/done/s/cout out)
//   Latency: start accepted at edge E0, nibbles added at E1..E_NIBBLES,
//   done high in the cycle after E_NIBBLES. Starts arriving while busy
//   (including the done cycle) are dropped.
// ---------------------------------------------------------------------------
module bocong_noitiep
  import bocong_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  bocong_noitiep_if.slave    bus
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  if (NIBBLES < 1 || NIBBLES > 16) begin : g_bad_nibbles
    $error("bocong_noitiep: NIBBLES must be in 1..16");
  end

  // ------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------
  state_t                         state_r;
  state_t                         state_nxt_s;

  logic [NIBBLES-1:0][NIB_W-1:0]  opa_r;
  logic [NIBBLES-1:0][NIB_W-1:0]  opb_r;
  logic [NIBBLES-1:0][NIB_W-1:0]  sum_r;
  logic [IDX_W-1:0]               idx_r;
  logic                           carry_r;
  logic                           cout_r;
  logic                           busy_r;
  logic                           done_r;

  // FSM decode strobes
  logic                           load_s;
  logic                           step_s;
  logic                           last_s;

  // Nibble adder hookup
  logic [NIB_W-1:0]               nib_a_s;
  logic [NIB_W-1:0]               nib_b_s;
  logic [NIB_W-1:0]               nib_sum_s;
  logic                           nib_cout_s;

  // ------------------------------------------------------------------
  // The one and only adder slice; idx selects which nibble it sees.
  // ------------------------------------------------------------------
  assign nib_a_s = opa_r[idx_r];
  assign nib_b_s = opb_r[idx_r];

  cong4bit u_cong4bit (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .cin  (carry_r),
    .cout (nib_cout_s),
    .s    (nib_sum_s)
  );

  // Next-state logic and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (idx_r == IDX_LAST) begin
          last_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        // start is deliberately not looked at here: no queuing.
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register plus busy/done flags registered from the next state,
  // so both outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand capture, carry chaining, nibble write-back and index counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_r   <= '0;
      opb_r   <= '0;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
    end else begin
      if (load_s) begin
        opa_r   <= bus.a;
        opb_r   <= bus.b;
        carry_r <= bus.cin;
        idx_r   <= '0;
      end else if (step_s) begin
        sum_r[idx_r] <= nib_sum_s;
        carry_r      <= nib_cout_s;
        if (last_s) begin
          // Park the index at 0 so it never walks past the top nibble.
          idx_r  <= '0;
          cout_r <= nib_cout_s;
        end else begin
          idx_r  <= idx_r + IDX_W'(1);
        end
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.s    = W'(sum_r);
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_bocong_noitiep.sv
// ---------------------------------------------------------------------------
// tb_bocong_noitiep
//   Self-checking bench for bocong_noitiep (NIBBLES=4, W=16). Expected sums
//   come from plain wide addition a + b + cin; timing expectations come from
//   the start-to-done latency of NIBBLES+1 edges.
// ---------------------------------------------------------------------------
module tb_bocong_noitiep;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int LAT     = NIBBLES + 1;

  logic clk = 1'b0;
  logic rst;

  int n_vec = 0;
  int n_err = 0;

  bocong_noitiep_if #(.NIBBLES(NIBBLES)) bus ();

  bocong_noitiep #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Directed vectors with their hand-computed results.
  logic [W-1:0] dir_a   [5] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h8000};
  logic [W-1:0] dir_b   [5] = '{16'h4321, 16'h0001, 16'hFFFF, 16'h0000, 16'h8000};
  logic         dir_c   [5] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
  logic [W-1:0] dir_s   [5] = '{16'h5555, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000};
  logic         dir_co  [5] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b1};

  // Reference: full-width unsigned sum.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv);
    return {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
  endfunction

  // Drive one request from a negedge and wait (bounded) for done.
  // edges counts rising edges from the accepting edge up to the cycle where
  // done is first seen. With hold=1, start stays high and a/b are scrambled.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input bit hold, output int edges, output bit timed_out);
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = cv;
    bus.start = 1'b1;
    edges     = 0;
    timed_out = 1'b1;
    for (int k = 0; k < 4 * LAT; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (hold) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 16'hA5A5;
    bus.b     = 16'h5A5A;
    bus.cin   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++; if (bus.s !== 16'h0000) begin n_err++; $display("FAIL reset_s: got %h want 0000", bus.s); end
    n_vec++; if (bus.cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_no_start: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_directed();
    int edges;
    bit to;
    for (int i = 0; i < 5; i++) begin
      run_op(dir_a[i], dir_b[i], dir_c[i], 1'b0, edges, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL dir%0d_timeout: done not seen within %0d edges", i, 4 * LAT); end
      n_vec++; if (edges !== LAT) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, edges, LAT); end
      n_vec++; if (bus.s !== dir_s[i]) begin n_err++; $display("FAIL dir%0d_s: got %h want %h", i, bus.s, dir_s[i]); end
      n_vec++; if (bus.cout !== dir_co[i]) begin n_err++; $display("FAIL dir%0d_cout: got %b want %b", i, bus.cout, dir_co[i]); end
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy_at_done: got %b want 1", i, bus.busy); end
      @(negedge clk);
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_width: got %b want 0", i, bus.done); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_idle: got %b want 0", i, bus.busy); end
    end
  endtask

  task automatic test_start_held();
    int edges;
    bit to;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, edges, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL held_timeout: done not seen"); end
    n_vec++; if (edges !== LAT) begin n_err++; $display("FAIL held_latency: got %0d want %0d", edges, LAT); end
    n_vec++; if (bus.s !== 16'h5555) begin n_err++; $display("FAIL held_s: got %h want 5555", bus.s); end
    n_vec++; if (bus.cout !== 1'b0) begin n_err++; $display("FAIL held_cout: got %b want 0", bus.cout); end
    // start still high through the done cycle: must not be taken there.
    bus.a   = 16'h0F0F;
    bus.b   = 16'h0101;
    bus.cin = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL held_done_ignored: busy got %b want 0", bus.busy); end
    // Still high in IDLE: taken at the next edge.
    run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, edges, to);
    n_vec++; if (edges !== LAT) begin n_err++; $display("FAIL held_next_latency: got %0d want %0d", edges, LAT); end
    n_vec++; if (bus.s !== 16'h1010) begin n_err++; $display("FAIL held_next_s: got %h want 1010", bus.s); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int edges;
    bit to;
    bit saw_done;
    logic [W:0] exp;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic cv;
    bus.a     = 16'hABCD;
    bus.b     = 16'h1111;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);            // E0: accepted
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);            // E1: first nibble
    @(negedge clk);
    rst = 1'b1;                // seen at E2, second RUN cycle
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (bus.s !== 16'h0000) begin n_err++; $display("FAIL midrst_s: got %h want 0000", bus.s); end
    n_vec++; if (bus.cout !== 1'b0) begin n_err++; $display("FAIL midrst_cout: got %b want 0", bus.cout); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    saw_done = 1'b0;
    for (int k = 0; k < 2 * LAT; k++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL midrst_no_done: got done pulse, want none"); end
    av  = W'($urandom);
    bv  = W'($urandom);
    cv  = 1'($urandom);
    exp = ref_sum(av, bv, cv);
    run_op(av, bv, cv, 1'b0, edges, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL midrst_fresh_timeout: done not seen"); end
    n_vec++; if ({bus.cout, bus.s} !== exp) begin n_err++; $display("FAIL midrst_fresh_sum: got %h want %h", {bus.cout, bus.s}, exp); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int edges;
    bit to;
    logic [W:0] exp;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic cv;
    for (int i = 0; i < 1000; i++) begin
      av  = W'($urandom);
      bv  = W'($urandom);
      cv  = 1'($urandom);
      exp = ref_sum(av, bv, cv);
      run_op(av, bv, cv, 1'b0, edges, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL rnd%0d_timeout: done not seen", i); end
      n_vec++; if (edges !== LAT) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, edges, LAT); end
      n_vec++; if ({bus.cout, bus.s} !== exp) begin n_err++; $display("FAIL rnd%0d_sum: a=%h b=%h cin=%b got %h want %h", i, av, bv, cv, {bus.cout, bus.s}, exp); end
      // One idle cycle: result must be held, flags low.
      @(negedge clk);
      n_vec++; if ({bus.cout, bus.s} !== exp) begin n_err++; $display("FAIL rnd%0d_idle_hold: got %h want %h", i, {bus.cout, bus.s}, exp); end
      n_vec++; if ({bus.busy, bus.done} !== 2'b00) begin n_err++; $display("FAIL rnd%0d_idle_flags: got %b want 00", i, {bus.busy, bus.done}); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    test_reset();
    test_directed();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bocong_noitiep.md
# bocong_noitiep

Nibble-serial multi-word adder that drives the team's 4-bit ripple-carry adder stage one nibble per clock and assembles the full-width sum. It accepts two W-bit operands plus carry-in on a start strobe and feeds nibbles LSB-first into a combinational 4-bit adder. It chains the carry between cycles in a register and presents the registered W-bit sum and final carry-out with a done pulse. Typical placement: between an operand register file and a result consumer where area matters more than latency.

## Interface
- NIBBLES, 4, number of 4-bit nibbles; W = 4*NIBBLES (default 16). Legal range 1..16.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  W  operand A, latched on accepted start.
- b  in  W  operand B, latched on accepted start.
- cin  in  1  carry-in, latched on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; s/cout valid.
- s  out  W  registered sum.
- cout  out  1  registered final carry-out.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch a→opa, b→opb, cin→carry; idx←0; go RUN. start=0: stay.
- RUN: combinational nibble add of opa[4*idx+:4] + opb[4*idx+:4] + carry.
- In RUN at each edge: 4-bit sum → s[4*idx+:4]; nibble carry-out → carry; idx←idx+1.
- RUN to DONE: at the edge where idx==NIBBLES-1, cout←nibble carry-out and state→DONE.
- DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
- start while busy=1, including the DONE cycle: ignored, no queuing.
- Arithmetic: {cout,s} = a + b + cin, modulo 2^(W+1), unsigned.
- Outputs s/cout hold the last result until the next accepted start completes.
- Nibbles of s update progressively during RUN. Consumers use s only when done=1 or busy=0.

## Timing
- Reset, any state: state=IDLE, idx=0, carry=0, s=0, cout=0, busy=0, done=0, opa=opb=0.
- Reset mid-operation: aborts the operation, clears to reset values, and raises no done.
- Start accepted at edge E0. RUN edges E1..E_NIBBLES. done=1 in the cycle after edge E_NIBBLES.
- Start-to-done latency: NIBBLES+1 edges (5 for the default).
- Next start earliest: the cycle after done, i.e. IDLE. Throughput is one operation per NIBBLES+2 cycles.
- busy rises in the cycle after the accepting edge and falls together with done.
- NIBBLES=1: one RUN cycle, then DONE.
- Critical path: one 4-bit ripple plus the idx mux.

## Structure
- Shared package bocong_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - nibble width constant NIB_W=4.
- Sub-module cong4bit: a combinational 4-bit ripple adder with ports a[3:0], b[3:0], cin, cout, s[3:0]. It is instantiated once.
- Top level contains the FSM, operand registers, idx counter (clog2(NIBBLES) bits, minimum 1), carry register, and the sum register.

## Test plan
- a=16'h1234, b=16'h4321, cin=0, start at edge 0 → done high after edge 4; s=16'h5555, cout=0.
- a=16'hFFFF, b=16'h0001, cin=0 → carry ripples across all four nibbles; s=16'h0000, cout=1.
- a=16'hFFFF, b=16'hFFFF, cin=1 → s=16'hFFFF, cout=1. Also a=b=0, cin=1 → s=16'h0001, cout=0.
- start held high through RUN and DONE with changed a/b → result unaffected (16'h1234+16'h4321 still gives 16'h5555); new operation starts only when start is sampled in IDLE.
- rst asserted on the second RUN cycle → next cycle s=0, cout=0, busy=0, and done never pulses. A fresh start then completes correctly.
- Random regression: 1000 random a, b, cin vectors back-to-back. Compare {cout,s} to a+b+cin at every done, check the 5-edge latency, and check s is stable while idle.
